// File: rtl/mssd_gen_pkg.sv
// Shared types and helpers for the mssd_gen serial message demultiplexer.
package mssd_gen_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      SEL  = 3'd1,
      LEN  = 3'd2,
      DATA = 3'd3,
      PAR  = 3'd4,
      STOP = 3'd5
   } state_t;

   localparam logic IDLE_LEVEL = 1'b1;

   // Select field needs at least one bit even for a single-port degenerate case
   function automatic int sel_width(input int ports);
      return (ports > 1) ? $clog2(ports) : 1;
   endfunction

endpackage

// File: rtl/mssd_shift_in.sv
// LSB-first serial field assembler with a per-field bit counter.
// word_c presents the completed field during the cycle its last bit is on bit_in.
module mssd_shift_in #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   input  logic         bit_in,
   output logic [W-1:0] word_c,
   output logic         last_c
);

   generate
      if (W > 1) begin : g_multi
         localparam int unsigned CNT_W = $clog2(W);

         logic [W-2:0]     shreg;
         logic [CNT_W-1:0] cnt;

         assign word_c = {bit_in, shreg};
         assign last_c = (cnt == CNT_W'(W - 1));

         // Counter self-clears after the last bit so the next field starts at zero
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               shreg <= '0;
               cnt   <= '0;
            end else if (en) begin
               shreg <= word_c[W-1:1];
               cnt   <= last_c ? '0 : cnt + CNT_W'(1);
            end
         end
      end else begin : g_single
         assign word_c = bit_in;
         assign last_c = 1'b1;
      end
   endgenerate

endmodule

// File: rtl/mssd_gen.sv
// Framed serial message demultiplexer: start, select, length, payload words, [parity], stop.
// Optional even-parity bit enabled by defining MSSD_GEN_PARITY_EN.
module mssd_gen
   import mssd_gen_pkg::*;
#(
   parameter int unsigned NUM_PORTS = 4,
   parameter int unsigned LEN_W     = 6,
   parameter int unsigned WORD_W    = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 s_in,
   output logic [WORD_W-1:0]    data_out,
   output logic                 word_valid,
   output logic [NUM_PORTS-1:0] port_sel,
   output logic                 busy,
   output logic                 frame_done,
   output logic                 error
);

   localparam int unsigned SEL_W = sel_width(NUM_PORTS);

`ifdef MSSD_GEN_PARITY_EN
   localparam state_t AFTER_PAY = PAR;
`else
   localparam state_t AFTER_PAY = STOP;
`endif

   state_t             state;
   logic [SEL_W-1:0]   sel_q;
   logic [LEN_W-1:0]   n_q;
   logic [LEN_W-1:0]   word_cnt;

   logic               sel_en_c, len_en_c, dat_en_c;
   logic [SEL_W-1:0]   sel_word_c;
   logic [LEN_W-1:0]   len_word_c;
   logic [WORD_W-1:0]  dat_word_c;
   logic               sel_last_c, len_last_c, dat_last_c;

   assign sel_en_c = (state == SEL);
   assign len_en_c = (state == LEN);
   assign dat_en_c = (state == DATA);

   mssd_shift_in #(.W(SEL_W)) u_sel (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (sel_en_c),
      .bit_in (s_in),
      .word_c (sel_word_c),
      .last_c (sel_last_c)
   );

   mssd_shift_in #(.W(LEN_W)) u_len (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (len_en_c),
      .bit_in (s_in),
      .word_c (len_word_c),
      .last_c (len_last_c)
   );

   mssd_shift_in #(.W(WORD_W)) u_dat (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (dat_en_c),
      .bit_in (s_in),
      .word_c (dat_word_c),
      .last_c (dat_last_c)
   );

`ifdef MSSD_GEN_PARITY_EN
   logic par_acc;

   // Running XOR over select, length and payload bits; start bit excluded
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         par_acc <= 1'b0;
      end else if (state == IDLE) begin
         par_acc <= 1'b0;
      end else if (state == SEL || state == LEN || state == DATA) begin
         par_acc <= par_acc ^ s_in;
      end
   end
`endif

   // Frame sequencer with registered outputs; pulses default low every cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         sel_q      <= '0;
         n_q        <= '0;
         word_cnt   <= '0;
         data_out   <= '0;
         word_valid <= 1'b0;
         port_sel   <= '0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         error      <= 1'b0;
      end else begin
         word_valid <= 1'b0;
         frame_done <= 1'b0;
         error      <= 1'b0;

         case (state)
            IDLE: begin
               if (s_in != IDLE_LEVEL) begin
                  state <= SEL;
                  busy  <= 1'b1;
               end
            end

            SEL: begin
               if (sel_last_c) begin
                  sel_q <= sel_word_c;
                  state <= LEN;
               end
            end

            LEN: begin
               if (len_last_c) begin
                  n_q <= len_word_c;
                  if (32'(sel_q) >= NUM_PORTS) begin
                     error <= 1'b1;
                     busy  <= 1'b0;
                     state <= IDLE;
                  end else if (len_word_c == '0) begin
                     state <= AFTER_PAY;
                  end else begin
                     port_sel <= NUM_PORTS'(1) << sel_q;
                     state    <= DATA;
                  end
               end
            end

            DATA: begin
               if (dat_last_c) begin
                  data_out   <= dat_word_c;
                  word_valid <= 1'b1;
                  if (word_cnt == n_q - LEN_W'(1)) begin
                     word_cnt <= '0;
                     port_sel <= '0;
                     state    <= AFTER_PAY;
                  end else begin
                     word_cnt <= word_cnt + LEN_W'(1);
                  end
               end
            end

`ifdef MSSD_GEN_PARITY_EN
            PAR: begin
               if (s_in == par_acc) begin
                  state <= STOP;
               end else begin
                  error <= 1'b1;
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
`endif

            STOP: begin
               if (s_in == IDLE_LEVEL) begin
                  frame_done <= 1'b1;
               end else begin
                  error <= 1'b1;
               end
               busy  <= 1'b0;
               state <= IDLE;
            end

            default: begin
               busy     <= 1'b0;
               port_sel <= '0;
               state    <= IDLE;
            end
         endcase
      end
   end

endmodule
